// File: rtl/ir_err_compute.sv
// IR line-sensor front end: sequences emitters and the 8-channel A2D, then forms a
// saturated, position-weighted signed line error once per sample.
module ir_err_compute #(
    parameter int unsigned SETTLE_CYC  = 4096,
    parameter int unsigned GAP_CYC     = 1024,
    parameter logic [11:0] LINE_THRESH = 12'h200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cnv_cmplt,
    input  logic [11:0]        res,
    output logic               IR_en,
    output logic               strt_cnv,
    output logic [2:0]         chnnl,
    output logic signed [15:0] error,
    output logic               err_vld,
    output logic               line_present
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC);
    localparam logic [GW-1:0] GAP_LOAD    = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, CONV, WAIT, DONE} state_t;

    state_t              state, nxt_state;
    logic [SW-1:0]       settle_cnt;
    logic [GW-1:0]       gap_cnt;
    logic signed [16:0]  accum;
    logic signed [16:0]  term;
    logic signed [16:0]  accum_nxt;
    logic                seen;
    logic                seen_nxt;
    logic                abort;
    logic                take;
    logic signed [15:0]  err_sat;

    assign abort = (state != IDLE) && !en;
    assign take  = (state == WAIT) && cnv_cmplt && en;

    // Weight is a shift by the pair index; odd channels are the right-hand sensors.
    assign term      = {5'b0, res} << chnnl[2:1];
    assign accum_nxt = chnnl[0] ? (accum - term) : (accum + term);
    assign seen_nxt  = seen || (res > LINE_THRESH);
    assign err_sat   = (accum_nxt[16] == accum_nxt[15]) ? accum_nxt[15:0] :
                       (accum_nxt[16] ? 16'sh8000 : 16'sh7FFF);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        if (abort) begin
            nxt_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (en && gap_cnt == '0) nxt_state = SETTLE;
                SETTLE:  if (settle_cnt == SETTLE_LAST) nxt_state = CONV;
                CONV:    nxt_state = WAIT;
                WAIT:    if (cnv_cmplt) nxt_state = (chnnl == 3'd7) ? DONE : CONV;
                DONE:    nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Outputs decode the state flop only, so nothing combinational reaches a port.
    always_comb begin
        IR_en    = 1'b0;
        strt_cnv = 1'b0;
        err_vld  = 1'b0;
        case (state)
            SETTLE:  IR_en = 1'b1;
            CONV:    begin IR_en = 1'b1; strt_cnv = 1'b1; end
            WAIT:    IR_en = 1'b1;
            DONE:    err_vld = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt   <= '0;
            gap_cnt      <= '0;
            chnnl        <= 3'd0;
            accum        <= '0;
            seen         <= 1'b0;
            error        <= '0;
            line_present <= 1'b0;
        end else begin
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;

            if (abort)                 gap_cnt <= '0;
            else if (state == DONE)    gap_cnt <= GAP_LOAD;
            else if (gap_cnt != '0)    gap_cnt <= gap_cnt - 1'b1;

            if (abort || (state == IDLE && nxt_state == SETTLE)) begin
                accum <= '0;
                seen  <= 1'b0;
            end else if (take) begin
                accum <= accum_nxt;
                seen  <= seen_nxt;
            end

            if (abort)
                chnnl <= 3'd0;
            else if (state == SETTLE && nxt_state == CONV)
                chnnl <= 3'd0;
            else if (take && chnnl != 3'd7)
                chnnl <= chnnl + 3'd1;

            // Results land on the same edge that raises err_vld.
            if (take && chnnl == 3'd7) begin
                error        <= err_sat;
                line_present <= seen_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ir_err_compute.sv
// Self-checking bench for ir_err_compute: directed and random samples against a
// plain-arithmetic model of the weighted line error.
module tb_ir_err_compute;

    localparam int SET = 16;
    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res = '0;
    logic        IR_en, strt_cnv, err_vld, line_present;
    logic [2:0]  chnnl;
    logic [15:0] err_o;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [11:0] rd [8];
    logic [15:0] exp_err = '0;
    logic        exp_lp = 1'b0;
    int          fixed_lat = 0;
    bit          junk = 1'b0;

    ir_err_compute #(.SETTLE_CYC(SET), .GAP_CYC(GAP), .LINE_THRESH(12'h200)) dut (
        .clk(clk), .rst(rst), .en(en), .cnv_cmplt(cnv_cmplt), .res(res),
        .IR_en(IR_en), .strt_cnv(strt_cnv), .chnnl(chnnl), .error(err_o),
        .err_vld(err_vld), .line_present(line_present)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, nm, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_err();
        int s = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) s += int'(rd[i]) * (1 << (i / 2));
            else            s -= int'(rd[i]) * (1 << (i / 2));
        end
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    function automatic logic model_lp();
        for (int i = 0; i < 8; i++)
            if (rd[i] > 12'h200) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_all(input logic [11:0] v);
        for (int i = 0; i < 8; i++) rd[i] = v;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 8; i++) rd[i] = 12'($urandom_range(0, 4095));
    endtask

    // One sample from IR_en rise to the next IR_en rise; optionally aborts on a channel.
    task automatic run_sample(input string tag, input int abort_ch, input bit abort_rst);
        int k;
        int lat;
        logic [15:0] me;
        logic        ml;
        k = 0;
        while (IR_en !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        chk(tag, "ir_en_rise", 32'(IR_en), 32'(1));
        if (IR_en !== 1'b1) return;
        k = 0;
        while (strt_cnv !== 1'b1 && k < 400) begin
            @(negedge clk); k++;
            if (junk && k == 3) begin cnv_cmplt = 1'b1; res = 12'hFFF; end
            else cnv_cmplt = 1'b0;
        end
        cnv_cmplt = 1'b0;
        chk(tag, "settle_len", 32'(k), 32'(SET + 1));
        for (int i = 0; i < 8; i++) begin
            chk(tag, $sformatf("strt%0d", i), 32'(strt_cnv), 32'(1));
            chk(tag, $sformatf("chnnl%0d", i), 32'(chnnl), 32'(i));
            if (junk) begin cnv_cmplt = 1'b1; res = 12'hFFF; end
            if (i == abort_ch) begin
                @(negedge clk); cnv_cmplt = 1'b0;
                if (abort_rst) rst = 1'b1; else en = 1'b0;
                @(negedge clk);
                if (abort_rst) begin exp_err = '0; exp_lp = 1'b0; end
                chk(tag, "abort_ir_en", 32'(IR_en), 32'(0));
                chk(tag, "abort_strt", 32'(strt_cnv), 32'(0));
                chk(tag, "abort_err", 32'(err_o), 32'(exp_err));
                chk(tag, "abort_lp", 32'(line_present), 32'(exp_lp));
                cnv_cmplt = 1'b1; res = 12'hFFF;
                @(negedge clk); cnv_cmplt = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    chk(tag, "abort_no_vld", 32'(err_vld), 32'(0));
                    chk(tag, "abort_idle", 32'(IR_en), 32'(0));
                    @(negedge clk);
                end
                chk(tag, "abort_chnnl", 32'(chnnl), 32'(0));
                chk(tag, "abort_err2", 32'(err_o), 32'(exp_err));
                rst = 1'b0; en = 1'b1;
                return;
            end
            lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
            repeat (lat) begin
                @(negedge clk); cnv_cmplt = 1'b0;
                if (strt_cnv !== 1'b0) chk(tag, "strt_in_wait", 32'(strt_cnv), 32'(0));
            end
            cnv_cmplt = 1'b1; res = rd[i];
            @(negedge clk); cnv_cmplt = 1'b0; res = 12'($urandom);
        end
        me = model_err();
        ml = model_lp();
        chk(tag, "err_vld", 32'(err_vld), 32'(1));
        chk(tag, "error", 32'(err_o), 32'(me));
        chk(tag, "line_present", 32'(line_present), 32'(ml));
        chk(tag, "done_ir_en", 32'(IR_en), 32'(0));
        exp_err = me; exp_lp = ml;
        @(negedge clk);
        chk(tag, "vld_one_cycle", 32'(err_vld), 32'(0));
        k = 1;
        while (IR_en !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        chk(tag, "gap_len", 32'(k), 32'(GAP + 1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset", "error", 32'(err_o), 32'(0));
        chk("reset", "err_vld", 32'(err_vld), 32'(0));
        chk("reset", "lp", 32'(line_present), 32'(0));
        chk("reset", "ir_en", 32'(IR_en), 32'(0));
        chk("reset", "strt", 32'(strt_cnv), 32'(0));
        chk("reset", "chnnl", 32'(chnnl), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("en_rise", "ir_en_next", 32'(IR_en), 32'(1));

        fixed_lat = 3;
        set_all(12'h000);                 run_sample("zeros", -1, 0);
        fixed_lat = 0;
        set_all(12'h000); rd[6] = 12'hFFF; run_sample("l3_only", -1, 0);
        set_all(12'h000); rd[7] = 12'hFFF; run_sample("r3_only", -1, 0);
        for (int i = 0; i < 8; i++) rd[i] = (i % 2 == 0) ? 12'hFFF : 12'h000;
        run_sample("left_sat", -1, 0);
        for (int i = 0; i < 8; i++) rd[i] = (i % 2 == 1) ? 12'hFFF : 12'h000;
        run_sample("right_sat", -1, 0);
        set_all(12'h200);                 run_sample("thresh_eq", -1, 0);
        set_all(12'h200); rd[1] = 12'h201; run_sample("thresh_gt", -1, 0);

        junk = 1'b1;
        set_rand();                       run_sample("junk_cmplt", -1, 0);
        junk = 1'b0;

        set_rand();                       run_sample("abort_en", 4, 0);
        set_rand();                       run_sample("after_en", -1, 0);
        set_rand();                       run_sample("abort_rst", 4, 1);
        set_rand();                       run_sample("after_rst", -1, 0);

        for (int n = 0; n < 6; n++) begin
            set_rand();
            run_sample($sformatf("rand%0d", n), -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
